// File: rtl/cpu24_pkg.sv
// Shared constants and state encoding for the 24-bit CPU data-side blocks.
package cpu24_pkg;
  localparam int CPU_WIDTH = 24;
  localparam int SB_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAINING = 2'd1,
    FLUSHING = 2'd2
  } sb_state_e;
endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the store buffer, grouped as one bundle.
interface store_buffer_if
  import cpu24_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int DEPTH = SB_DEPTH
);
  logic                     CpuStore;
  logic                     CpuLoad;
  logic [WIDTH-1:0]         CpuAddress;
  logic [WIDTH-1:0]         CpuWriteData;
  logic                     Flush;
  logic                     StoreReady;
  logic [WIDTH-1:0]         LoadData;
  logic                     LoadStall;
  logic [WIDTH-1:0]         MemAddress;
  logic [WIDTH-1:0]         MemWriteData;
  logic                     MemWrite;
  logic                     MemRead;
  logic [WIDTH-1:0]         MemReadData;
  logic                     Empty;
  logic                     Full;
  logic [$clog2(DEPTH):0]   Count;

  modport slave (
    input  CpuStore, CpuLoad, CpuAddress, CpuWriteData, Flush, MemReadData,
    output StoreReady, LoadData, LoadStall, MemAddress, MemWriteData,
           MemWrite, MemRead, Empty, Full, Count
  );

  modport master (
    output CpuStore, CpuLoad, CpuAddress, CpuWriteData, Flush, MemReadData,
    input  StoreReady, LoadData, LoadStall, MemAddress, MemWriteData,
           MemWrite, MemRead, Empty, Full, Count
  );
endinterface

// File: rtl/store_buffer_fifo.sv
// Pending-store storage: circular entry array, head/tail pointers and occupancy.
// Entries are presented oldest-first so the parent can scan them by age.
module store_buffer_fifo
  import cpu24_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_addr_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       age_addr_o [DEPTH],
  output logic [WIDTH-1:0]       age_data_o [DEPTH],
  output logic [DEPTH-1:0]       age_vld_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (push_i) begin
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end
    if (pop_i) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload needs no reset: an entry is only visible through its valid bit.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx           = head_q + PW'(i);
      age_addr_o[i] = addr_q[idx];
      age_data_o[i] = data_q[idx];
      age_vld_o[i]  = vld_q[idx];
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/store_buffer.sv
// CPU store buffer: queues stores, drains them to memory when the port is free,
// forwards exact-address loads and stalls loads that partially overlap a pending store.
module store_buffer
  import cpu24_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic         Clock,
  input  logic         Reset,
  store_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  sb_state_e        state_q, state_d;
  logic [WIDTH-1:0] age_addr [DEPTH];
  logic [WIDTH-1:0] age_data [DEPTH];
  logic [DEPTH-1:0] age_vld;
  logic [CW-1:0]    count;
  logic             empty, full, store_rdy;
  logic             push, pop, load_v, raw_stall, port_load, mem_rd;
  logic             fwd_hit, ovl;
  logic [WIDTH-1:0] fwd_data;

  function automatic logic addr_near(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return (d == WIDTH'(1)) || (d == WIDTH'(2));
  endfunction

  store_buffer_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .push_i      (push),
    .push_addr_i (bus.CpuAddress),
    .push_data_i (bus.CpuWriteData),
    .pop_i       (pop),
    .age_addr_o  (age_addr),
    .age_data_o  (age_data),
    .age_vld_o   (age_vld),
    .count_o     (count)
  );

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign store_rdy = !Reset && !full && (state_q != FLUSHING);
  assign push      = bus.CpuStore && store_rdy;

  // Oldest-to-youngest scan: a younger exact match hides older partial overlaps.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    ovl      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i]) begin
        if (age_addr[i] == bus.CpuAddress) begin
          fwd_hit  = 1'b1;
          fwd_data = age_data[i];
          ovl      = 1'b0;
        end else if (addr_near(age_addr[i], bus.CpuAddress)) begin
          ovl = 1'b1;
        end
      end
    end
  end

  // A store+load from the CPU still reserves the port so stores can pile up behind it.
  always_comb begin
    load_v    = bus.CpuLoad && !bus.CpuStore && !Reset;
    raw_stall = (state_q == FLUSHING) || ovl;
    port_load = bus.CpuLoad && !raw_stall;
    mem_rd    = load_v && !raw_stall;
    pop       = !Reset && !empty && !port_load;
  end

  always_comb begin
    bus.StoreReady   = store_rdy;
    bus.Empty        = empty;
    bus.Full         = full;
    bus.Count        = count;
    bus.MemRead      = mem_rd;
    bus.MemWrite     = pop;
    bus.LoadStall    = load_v && raw_stall;
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    bus.LoadData     = '0;
    if (mem_rd) begin
      bus.MemAddress = bus.CpuAddress;
      bus.LoadData   = fwd_hit ? fwd_data : bus.MemReadData;
    end else if (pop) begin
      bus.MemAddress   = age_addr[0];
      bus.MemWriteData = age_data[0];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (push) state_d = DRAINING;
      DRAINING: if (pop && !push && (count == CW'(1))) state_d = IDLE;
      FLUSHING: if (empty || (pop && (count == CW'(1)))) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (bus.Flush) state_d = FLUSHING;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 24, address and data width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port Clock  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port CpuStore  input  1  store request this cycle.
REQ-007 SHALL have port CpuLoad  input  1  load request this cycle.
REQ-008 SHALL have port CpuAddress  input  WIDTH  byte address of load/store.
REQ-009 SHALL have port CpuWriteData  input  WIDTH  store data, big-endian 3 bytes.
REQ-010 SHALL have port Flush  input  1  pulse; drain all entries.
REQ-011 SHALL have port StoreReady  output  1  store will be accepted.
REQ-012 SHALL have port LoadData  output  WIDTH  load result.
REQ-013 SHALL have port LoadStall  output  1  load cannot complete this cycle.
REQ-014 SHALL have port MemAddress, MemWriteData  output  WIDTH each  to data memory.
REQ-015 SHALL have port MemWrite, MemRead  output  1 each  to data memory.
REQ-016 SHALL have port MemReadData  input  WIDTH  combinational data from memory.
REQ-017 SHALL have ports Empty, Full  output  1 each, and Count  output  $clog2(DEPTH)+1.

Function
REQ-018 SHALL hold stores in FIFO order; enqueue at posedge when CpuStore && StoreReady.
REQ-019 SHALL drive StoreReady = !Full && state != FLUSHING; no enqueue-while-full bypass even if a drain pops the same cycle.
REQ-020 SHALL own the memory port: load access takes priority over drain unless LoadStall is high.
REQ-021 SHALL, when non-empty and port free, drive MemWrite=1, MemAddress/MemWriteData=head entry; pop at that posedge (one store per cycle).
REQ-022 SHALL, on CpuLoad, drive MemRead=1, MemAddress=CpuAddress, MemWrite=0.
REQ-023 SHALL forward: load address equal to any valid entry address -> LoadData = youngest matching entry data, same cycle.
REQ-024 SHALL detect partial overlap: entry with |CpuAddress-entry| in {1,2} (24-bit unsigned, no wrap) and no exact match younger than it -> LoadStall=1.
REQ-025 SHALL, while LoadStall=1, drain head each cycle; LoadStall falls when no overlapping entry remains, load then reads memory.
REQ-026 SHALL otherwise return LoadData = MemReadData (zero added latency).
REQ-027 SHALL keep LoadData=0 and LoadStall=0 when CpuLoad=0.
REQ-028 SHALL implement states IDLE (empty), DRAINING (non-empty), FLUSHING; IDLE->DRAINING on enqueue; DRAINING->IDLE when last entry pops with no enqueue; Flush in any state -> FLUSHING; FLUSHING->IDLE when empty.
REQ-029 SHALL, in FLUSHING, drain every cycle regardless of CpuLoad, and hold LoadStall=1 for any load.
REQ-030 SHALL, on simultaneous enqueue and pop, keep Count unchanged; pointers wrap modulo DEPTH.
REQ-031 SHALL ignore CpuStore and CpuLoad both high (store taken, load treated as absent) -- illegal from CPU.

Reset
REQ-032 SHALL on Reset clear pointers, Count=0, all entry valid bits, state=IDLE, immediately.
REQ-033 SHALL hold during reset: Empty=1, Full=0, StoreReady=0, MemWrite=0, MemRead=0, LoadStall=0, LoadData=0, MemAddress=0, MemWriteData=0.
REQ-034 SHALL discard pending stores on reset mid-drain; no partial memory write after deassertion.

Structure
REQ-035 SHALL place WIDTH, default DEPTH and state encoding (IDLE=0, DRAINING=1, FLUSHING=2) in shared package cpu24_pkg.
REQ-036 SHALL implement entry storage, pointers and Count in sub-module store_buffer_fifo; forwarding/overlap and FSM in store_buffer.

Verification
REQ-037 Store 0x000010/0xAABBCC, no load -> next cycle MemWrite=1, MemAddress=0x000010, MemWriteData=0xAABBCC; then Empty=1.
REQ-038 Stores to 0x20 (0x111111) then 0x20 (0x222222), load 0x20 same cycle as second drain pending -> LoadData=0x222222, LoadStall=0.
REQ-039 Store 0x30 pending, load 0x31 -> LoadStall=1 until 0x30 drained; then LoadData=memory bytes 0x31..0x33.
REQ-040 Four stores with continuous loads to 0x70 -> Full=1, StoreReady=0, no MemWrite; loads stop -> four drains in order, Count 4,3,2,1,0.
REQ-041 Flush with 3 entries and CpuLoad high -> FLUSHING, 3 consecutive MemWrite, LoadStall=1 throughout, IDLE after.
REQ-042 Reset asserted with 2 entries mid-drain -> Count=0, MemWrite=0 immediately; no writes after release.
